// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction port of the memory and
// hands instruction words plus PC to decode over a valid/ready handshake.
module fetch_stage #(
  parameter int WIDTH = 32,
  parameter int INSTRUCTIONWIDTH = 24,
  parameter logic [WIDTH-1:0] RESETPC = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic [WIDTH-1:0]            imem_addr,
  input  logic [INSTRUCTIONWIDTH-1:0] imem_rdata,
  output logic                        valid_d,
  input  logic                        ready_d,
  output logic [INSTRUCTIONWIDTH-1:0] instr_d,
  output logic [WIDTH-1:0]            pc_d,
  input  logic                        redirect_valid,
  input  logic [WIDTH-1:0]            redirect_pc,
  input  logic                        halt_req,
  output logic                        halted,
  output logic [WIDTH-1:0]            fetch_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] req_pc;
  logic [WIDTH-1:0] req_pc_nx;
  logic             req_valid;
  logic             req_valid_nx;
  logic [WIDTH-1:0] count;
  logic             redir;
  logic             fire;

  // A halt request takes priority, so a simultaneous redirect is ignored
  assign redir = redirect_valid & ~halt_req;

  assign valid_d     = (state == RUN) & req_valid & ~redir;
  assign fire        = valid_d & ready_d;
  assign pc_d        = req_pc;
  assign instr_d     = imem_rdata;
  assign halted      = (state == HALTED);
  assign fetch_count = count;

  always_comb begin
    imem_addr = req_pc + ONE;
    if (state == IDLE)
      imem_addr = RESETPC;
    else if (state == HALTED)
      imem_addr = req_pc;
    else if (halt_req)
      imem_addr = req_pc;
    else if (redirect_valid)
      imem_addr = redirect_pc;
    else if (!ready_d)
      imem_addr = req_pc;
  end

  always_comb begin
    state_nx     = state;
    req_pc_nx    = req_pc;
    req_valid_nx = req_valid;
    unique case (state)
      IDLE: begin
        state_nx     = RUN;
        req_pc_nx    = RESETPC;
        req_valid_nx = 1'b1;
      end
      RUN: begin
        req_pc_nx = imem_addr;
        if (halt_req) begin
          state_nx     = HALTED;
          req_valid_nx = 1'b0;
        end else begin
          req_valid_nx = 1'b1;
        end
      end
      HALTED: begin
        state_nx = HALTED;
      end
      default: begin
        state_nx     = IDLE;
        req_pc_nx    = RESETPC;
        req_valid_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_pc    <= RESETPC;
      req_valid <= 1'b0;
      count     <= '0;
    end else begin
      state     <= state_nx;
      req_pc    <= req_pc_nx;
      req_valid <= req_valid_nx;
      if (fire)
        count <= count + ONE;
    end
  end

endmodule
